cache_fill_fsm: RTL and testbench

//   Miss responder between an L1 cache (I or D) and multi-cycle, pipelined main memory.
//   On a cache miss it fetches the 8-word (16-byte) block containing the missed address.

---
 rtl/cache_fill_fsm.sv | 120 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Miss responder: fetches the block containing a missed address from pipelined main memory,
// writes each returned word into the cache data array, then writes the tag.
module cache_fill_fsm #(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned ADDR_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    output logic                               fsm_busy,
    output logic                               mem_en,
    output logic [ADDR_W-1:0]                  memory_address,
    input  logic                               memory_data_valid,
    input  logic [15:0]                        memory_data,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic [15:0]                        fill_data,
    output logic                               write_tag_array
);

    localparam int unsigned CntW = $clog2(WORDS_PER_BLOCK);
    localparam logic [CntW-1:0] LastIdx = CntW'(WORDS_PER_BLOCK - 1);
    // Byte offset bits within a block (two bytes per word).
    localparam logic [ADDR_W-1:0] OffMask = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CntW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0]   recv_cnt_q, recv_cnt_d;
    logic              recv_fire;

    // Returns are only meaningful while a fill is outstanding.
    assign recv_fire = memory_data_valid && (state_q != StIdle);

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word        = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;

        case (state_q)
            StIdle: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    base_d  = miss_address & ~OffMask;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                fsm_busy       = 1'b1;
                mem_en         = 1'b1;
                memory_address = base_q + ADDR_W'({issue_cnt_q, 1'b0});
                issue_cnt_d    = issue_cnt_q + CntW'(1);
                if (issue_cnt_q == LastIdx) begin
                    issue_cnt_d = '0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                fsm_busy = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (recv_fire) begin
            write_data_array = 1'b1;
            fill_word        = recv_cnt_q;
            fill_data        = memory_data;
            recv_cnt_d       = recv_cnt_q + CntW'(1);
            if (recv_cnt_q == LastIdx) begin
                write_tag_array = 1'b1;
                recv_cnt_d      = '0;
                issue_cnt_d     = '0;
                state_d         = StIdle;
            end
        end

        // Reset silences every output in the same cycle, not just from the next edge.
        if (rst) begin
            fsm_busy         = 1'b0;
            mem_en           = 1'b0;
            memory_address   = '0;
            write_data_array = 1'b0;
            fill_word        = '0;
            fill_data        = '0;
            write_tag_array  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a fixed cycle table for the basic fill, then directed and random
// fills against a queue-based memory and block-fill reference model.
module tb_cache_fill_fsm;

    localparam int WPB = 8;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;

    always #5 clk = ~clk;

    cache_fill_fsm #(
        .WORDS_PER_BLOCK(WPB),
        .ADDR_W         (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .fsm_busy         (fsm_busy),
        .mem_en           (mem_en),
        .memory_address   (memory_address),
        .memory_data_valid(memory_data_valid),
        .memory_data      (memory_data),
        .write_data_array (write_data_array),
        .fill_word        (fill_word),
        .fill_data        (fill_data),
        .write_tag_array  (write_tag_array)
    );

    typedef struct {
        logic        miss;
        logic [15:0] maddr;
        logic        valid;
        logic [15:0] mdata;
        logic        busy;
        logic        en;
        logic [15:0] addr;
        logic        wr;
        logic [2:0]  word;
        logic [15:0] fdata;
        logic        tag;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    vec_t        tbl[14];
    ret_t        pend[$];
    logic [15:0] ready[$];

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    string tname    = "reset";

    // Reference model: one fill = 8 queued request addresses plus a count of words received.
    bit          m_active = 1'b0;
    logic [15:0] m_req[$];
    int          m_nrecv  = 0;
    logic [15:0] m_base   = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s cycle=%0d actual=0x%0h expected=0x%0h", tname, nm, cyc, act, exp);
        end
    endtask

    task automatic chk_outs(input logic busy, input logic en, input logic [15:0] addr,
                            input logic wr, input logic [2:0] word, input logic [15:0] fdata,
                            input logic tag);
        chk("fsm_busy", 32'(fsm_busy), 32'(busy));
        chk("mem_en", 32'(mem_en), 32'(en));
        chk("memory_address", 32'(memory_address), 32'(addr));
        chk("write_data_array", 32'(write_data_array), 32'(wr));
        chk("fill_word", 32'(fill_word), 32'(word));
        chk("fill_data", 32'(fill_data), 32'(fdata));
        chk("write_tag_array", 32'(write_tag_array), 32'(tag));
    endtask

    // One clock cycle: entered 1 time unit after a rising edge, leaves at the same point.
    task automatic step(input logic miss, input logic [15:0] addr, input logic r,
                        input logic gap, input logic fvalid);
        ret_t        t;
        logic        e_en, e_wr, e_tag;
        logic [15:0] e_addr, e_data;
        logic [2:0]  e_word;
        bit          was_active;
        rst           = r;
        miss_detected = miss;
        miss_address  = addr;
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            t = pend.pop_front();
            ready.push_back(t.data);
        end
        if (fvalid) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'h5A5A;
        end else if (ready.size() > 0 && !gap) begin
            memory_data_valid = 1'b1;
            memory_data       = ready.pop_front();
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'($urandom);
        end
        #2;
        if (r) begin
            chk_outs(1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
            m_active = 1'b0;
            m_req.delete();
            m_nrecv = 0;
        end else begin
            e_en   = (m_req.size() > 0);
            e_addr = e_en ? m_req[0] : 16'h0;
            e_wr   = memory_data_valid && m_active;
            e_word = e_wr ? 3'(m_nrecv) : 3'd0;
            e_data = e_wr ? ((m_base + 16'(2 * m_nrecv)) ^ 16'hA5A5) : 16'h0;
            e_tag  = e_wr && (m_nrecv == WPB - 1);
            chk_outs(m_active || miss, e_en, e_addr, e_wr, e_word, e_data, e_tag);
            was_active = m_active;
            if (e_en) void'(m_req.pop_front());
            if (e_wr) begin
                m_nrecv++;
                if (m_nrecv == WPB) begin
                    m_active = 1'b0;
                    m_nrecv  = 0;
                end
            end
            if (!was_active && miss) begin
                m_active = 1'b1;
                m_base   = addr - (addr % 16'(2 * WPB));
                for (int i = 0; i < WPB; i++) m_req.push_back(m_base + 16'(2 * i));
            end
        end
        if (mem_en === 1'b1) pend.push_back('{cyc + LAT, memory_address ^ 16'hA5A5});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((m_active || pend.size() > 0 || ready.size() > 0) && n < maxc) begin
            step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            failures++;
            $display("FAIL %s/timeout cycle=%0d actual=still_busy expected=idle_within_%0d",
                     tname, cyc, maxc);
        end
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit       drain_req;
        logic     r, m;
        logic [15:0] a;

        // Basic fill of 0x1236 as a fixed cycle table (memory latency 4).
        for (int c = 0; c < 14; c++) begin
            tbl[c]       = '{default: '0};
            tbl[c].miss  = (c == 0);
            tbl[c].maddr = (c == 0) ? 16'h1236 : 16'h0;
            tbl[c].busy  = (c <= 12);
            tbl[c].en    = (c >= 1 && c <= 8);
            tbl[c].addr  = tbl[c].en ? 16'(16'h1230 + 2 * (c - 1)) : 16'h0;
            tbl[c].valid = (c >= 5 && c <= 12);
            tbl[c].wr    = tbl[c].valid;
            tbl[c].mdata = tbl[c].valid ? (16'(16'h1230 + 2 * (c - 5)) ^ 16'hA5A5) : 16'h0;
            tbl[c].fdata = tbl[c].mdata;
            tbl[c].word  = tbl[c].valid ? 3'(c - 5) : 3'd0;
            tbl[c].tag   = (c == 12);
        end

        rst               = 1'b1;
        miss_detected     = 1'b1;
        miss_address      = 16'h1236;
        memory_data_valid = 1'b1;
        memory_data       = 16'hFFFF;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk_outs(1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
            @(posedge clk);
            #1;
        end

        tname = "table_fill_1236";
        cyc   = 0;
        for (int c = 0; c < 14; c++) begin
            rst               = 1'b0;
            miss_detected     = tbl[c].miss;
            miss_address      = tbl[c].maddr;
            memory_data_valid = tbl[c].valid;
            memory_data       = tbl[c].mdata;
            #2;
            chk_outs(tbl[c].busy, tbl[c].en, tbl[c].addr, tbl[c].wr, tbl[c].word,
                     tbl[c].fdata, tbl[c].tag);
            @(posedge clk);
            #1;
            cyc++;
        end

        tname = "miss_held_during_fill";
        cyc   = 0;
        step(1'b1, 16'h1236, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 13; i++) step(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
        drain(60);

        tname = "valid_gap_after_word3";
        cyc   = 0;
        step(1'b1, 16'h3000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) step(1'b0, 16'h0, 1'b0, (i == 9 || i == 10), 1'b0);
        drain(60);

        tname = "reset_mid_fill";
        cyc   = 0;
        step(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) step(1'b0, 16'h0, (i == 6), 1'b0, 1'b0);
        drain(60);
        step(1'b1, 16'h2000, 1'b0, 1'b0, 1'b0);
        drain(60);

        tname = "idle_valid_no_miss";
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        tname = "miss_fffa_no_wrap";
        step(1'b1, 16'hFFFA, 1'b0, 1'b0, 1'b0);
        drain(60);

        tname     = "random";
        drain_req = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            if (r) drain_req = 1'b1;
            else if (pend.size() == 0 && ready.size() == 0) drain_req = 1'b0;
            m = !drain_req && ($urandom_range(0, 3) == 0);
            a = 16'($urandom);
            step(m, a, r, ($urandom_range(0, 4) == 0), 1'b0);
        end
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
